seven_seg_mux: RTL and testbench
================================

// Module: seven_seg_mux
// PURPOSE
//   Parametrised multiplexed 7-segment display driver; next generation of the 4-digit BCD scanner.
//   Scans DIGITS digits using a clock-enable tick (no derived clock). Full hex decode, per-digit
//   decimal points, optional leading-zero blanking, 16-level PWM brightness, selectable polarity.
//   Sits between the value-producing logic and the board anode/cathode pins.
// PARAMETERS
//   DIGITS            8       number of digits scanned (2..8)
//   CLK_DIV           100000  i_clk cycles per digit slot; must be a multiple of 16 and >= 16
//   ANODE_ACTIVE_LOW  1       1: anode drive active-low; 0: active-high
//   SEG_ACTIVE_LOW    1       1: segment/dp drive active-low; 0: active-high
// PORTS
//   i_clk         in   1          system clock; all logic on posedge
//   i_resetn      in   1          asynchronous, active-low reset
//   i_value       in   4*DIGITS   nibble k = digit k (digit 0 = rightmost)
//   i_dp          in   DIGITS     bit k lights decimal point of digit k
//   i_blank_lz    in   1          1: blank leading zero digits
//   i_brightness  in   4          0 = 1/16 duty .. 15 = full duty
//   o_cathode     out  8          segments {dp,g,f,e,d,c,b,a}, bit0 = a
//   o_anode       out  DIGITS     digit enables, at most one active
// BEHAVIOUR
//   - Reset (async, i_resetn=0): slot counter=0, digit index=0, snapshot regs=0, o_anode and
//     o_cathode all inactive (level per polarity params). Outputs stay inactive while in reset.
//   - Slot counter counts 0..CLK_DIV-1 and wraps; at CLK_DIV-1 digit index advances 0,1,..,DIGITS-1,0.
//   - Snapshot: i_value, i_dp, i_blank_lz, i_brightness sampled together on the cycle counter==CLK_DIV-1
//     with index==DIGITS-1 (frame boundary); inputs change display only at frame start, never
//     mid-frame. First frame after reset shows snapshot-zero contents: "0" on every digit, dp off,
//     brightness 0.
//   - Digit on-time: anode for current index active while counter < (brightness+1)*(CLK_DIV/16),
//     inactive for the rest of the slot. brightness=15 -> active whole slot.
//   - Decode (active-high before polarity): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F
//     A:77 b:7C C:39 d:5E E:79 F:71; bit7 = dp snapshot bit for that digit.
//   - Leading-zero blank: when enabled, digits from DIGITS-1 downward whose nibble is 0 are blanked
//     until the first nonzero nibble; digit 0 never blanked. A blanked digit with its dp bit set
//     still shows dp only (segments a-g off); without dp, anode stays inactive for the slot.
//   - Outputs registered: o_anode/o_cathode reflect counter/index state with 1-cycle latency.
//     Segment and anode change on the same cycle; cathode is set inactive whenever anode is inactive.
//   - Polarity: final output = active-high value XOR {width{ACTIVE_LOW}}.
//   - Reset asserted mid-frame: outputs go inactive immediately (async); scan restarts at digit 0,
//     counter 0 after release.
// TESTING
//   (bench: DIGITS=4, CLK_DIV=16, both polarities active-low)
//   1 reset held, toggle inputs -> o_anode=4'hF, o_cathode=8'hFF throughout; release -> digit 0
//     active 1 cycle after first edge, shows "0" (o_cathode=8'hC0) for 1 cycle at brightness 0.
//   2 i_value=16'h12AF, brightness=15, after one frame -> slots show F,A,2,1 on anodes E,D,B,7,
//     each active 16 cycles; cathodes 8E,88,A4,F9.
//   3 i_value=16'h0070, i_blank_lz=1, i_dp=4'b1000 -> digit 3: dp only (o_cathode=8'h7F);
//     digit 2: anode inactive entire slot; digit 1 = 7 (F8); digit 0 = 0 (C0).
//   4 brightness=3 -> anode active exactly 4 of 16 cycles per slot; brightness 0 -> 1 of 16.
//   5 change i_value mid-frame -> outputs unchanged until next frame start, then new value.
//   6 parameters flipped to active-high, value 16'h8888 -> o_cathode=8'h7F, one anode bit high;
//     assert reset mid-slot -> o_anode=0, o_cathode=0 same cycle.

Source files
------------

// File: rtl/seven_seg_mux.sv
// Multiplexed hex 7-segment driver: one digit per slot, input snapshot per frame,
// PWM on-time per slot, leading-zero blanking and configurable pin polarity.
module seven_seg_mux #(
    parameter int DIGITS           = 8,
    parameter int CLK_DIV          = 100000,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic                  i_blank_lz,
    input  logic [3:0]            i_brightness,
    output logic [7:0]            o_cathode,
    output logic [DIGITS-1:0]     o_anode
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int STEP  = CLK_DIV / 16;
    localparam logic [DIGITS-1:0] AN_OFF  = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] snap_value;
    logic [DIGITS-1:0]   snap_dp;
    logic                snap_blz;
    logic [3:0]          snap_bright;

    logic                slot_end;
    logic                frame_end;
    logic [DIGITS-1:0]   lz_blank;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                on_time;
    logic                show;
    logic [DIGITS-1:0]   an_nxt;
    logic [7:0]          cath_nxt;

    function automatic logic [6:0] seg_dec(input logic [3:0] n);
        case (n)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign slot_end  = (cnt == CNT_W'(CLK_DIV - 1));
    assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));

    // A digit is blanked while every nibble from the top down to it is zero; digit 0 always shows.
    always_comb begin
        logic zero_run;
        zero_run = snap_blz;
        lz_blank = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run && (snap_value[4*k +: 4] == 4'h0);
            lz_blank[k] = zero_run;
        end
    end

    always_comb begin
        cur_nib   = snap_value[{idx, 2'b00} +: 4];
        cur_dp    = snap_dp[idx];
        cur_blank = lz_blank[idx];
        on_time   = (32'(cnt) < (32'(snap_bright) + 32'd1) * 32'(STEP));
        show      = on_time && !(cur_blank && !cur_dp);
        an_nxt    = show ? (DIGITS'(1) << idx) : '0;
        cath_nxt  = show ? {cur_dp, (cur_blank ? 7'h00 : seg_dec(cur_nib))} : 8'h00;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            cnt         <= '0;
            idx         <= '0;
            snap_value  <= '0;
            snap_dp     <= '0;
            snap_blz    <= 1'b0;
            snap_bright <= 4'h0;
            o_anode     <= AN_OFF;
            o_cathode   <= SEG_OFF;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (frame_end) begin
                snap_value  <= i_value;
                snap_dp     <= i_dp;
                snap_blz    <= i_blank_lz;
                snap_bright <= i_brightness;
            end
            o_anode   <= an_nxt ^ AN_OFF;
            o_cathode <= cath_nxt ^ SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Bench for seven_seg_mux: random inputs against a time-indexed frame model, plus
// directed reset, decode, blanking and active-high polarity checks.
module tb_seven_seg_mux;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 16;
    localparam int STEP    = CLK_DIV / 16;
    localparam int FRAME   = DIGITS * CLK_DIV;
    localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, rst2_n;

    logic [15:0] value;
    logic [3:0]  dp;
    logic        blz;
    logic [3:0]  bright;
    logic [7:0]  cath, cath2;
    logic [3:0]  an, an2;

    int n_checks = 0;
    int n_fail   = 0;

    seven_seg_mux #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut (
        .i_clk(clk), .i_resetn(rst_n), .i_value(value), .i_dp(dp), .i_blank_lz(blz),
        .i_brightness(bright), .o_cathode(cath), .o_anode(an)
    );

    seven_seg_mux #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)) dut_hi (
        .i_clk(clk), .i_resetn(rst2_n), .i_value(value), .i_dp(dp), .i_blank_lz(blz),
        .i_brightness(bright), .o_cathode(cath2), .o_anode(an2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {anode, cathode} (active-low pins) for time t within a frame built from snapshot s_*.
    function automatic logic [11:0] model_out(input logic [15:0] v, input logic [3:0] d, input logic bz,
                                              input logic [3:0] br, input int slot, input int pos);
        int top;
        int nib;
        logic blanked, lit, shown;
        logic [3:0] an_h;
        logic [7:0] ca_h;
        top = 0;
        for (int k = 0; k < DIGITS; k++)
            if (((v >> (4 * k)) & 16'hF) != 0) top = k;
        blanked = bz && (slot > top);
        nib     = int'((v >> (4 * slot)) & 16'hF);
        lit     = pos < (int'(br) + 1) * STEP;
        shown   = lit && !(blanked && !d[slot]);
        an_h    = shown ? 4'(1 << slot) : 4'h0;
        ca_h    = shown ? {d[slot], (blanked ? 7'h00 : SEG_TAB[nib])} : 8'h00;
        return {~an_h, ~ca_h};
    endfunction

    // scoreboard: model produces one expectation per edge, checker consumes on the falling edge
    logic [11:0] exp_q[$];
    int          t;
    logic [15:0] s_value;
    logic [3:0]  s_dp, s_bright;
    logic        s_blz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0;
            s_value = '0; s_dp = '0; s_blz = 1'b0; s_bright = '0;
            exp_q.delete();
            exp_q.push_back(12'hFFF);
        end else begin
            exp_q.push_back(model_out(s_value, s_dp, s_blz, s_bright, (t % FRAME) / CLK_DIV, t % CLK_DIV));
            if (t % FRAME == FRAME - 1) begin
                s_value = value; s_dp = dp; s_blz = blz; s_bright = bright;
            end
            t++;
        end
    end

    always @(negedge clk) begin
        logic [11:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scan", {20'h0, an, cath}, {20'h0, e});
        end
    end

    // driver tasks
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [15:0] v, input logic [3:0] d, input logic bz, input logic [3:0] br);
        value = v; dp = d; blz = bz; bright = br;
    endtask

    task automatic drive_random();
        logic [15:0] v;
        for (int k = 0; k < 4; k++)
            v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        drive(v, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    endtask

    task automatic async_reset_pulse();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_an", {28'h0, an}, 32'hF);
        check("arst_cath", {24'h0, cath}, 32'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rst2_n = 1'b0;
        drive(16'h0, 4'h0, 1'b0, 4'h0);

        // inputs toggling under reset must not disturb the inactive outputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_random();
            #1;
            check("rst_an", {28'h0, an}, 32'hF);
            check("rst_cath", {24'h0, cath}, 32'hFF);
            check("rst_an_hi", {28'h0, an2}, 32'h0);
            check("rst_cath_hi", {24'h0, cath2}, 32'h0);
        end

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_an", {28'h0, an}, 32'hE);
        check("rel_cath", {24'h0, cath}, 32'hC0);
        @(posedge clk);
        #1;
        check("rel_off", {28'h0, an}, 32'hF);

        @(negedge clk);
        drive(16'h12AF, 4'h0, 1'b0, 4'hF);
        wait_cycles(2 * FRAME);
        drive(16'h0070, 4'b1000, 1'b1, 4'hF);
        wait_cycles(2 * FRAME);
        drive(16'h0070, 4'b1000, 1'b1, 4'h3);
        wait_cycles(2 * FRAME);
        drive(16'h5A3C, 4'b0101, 1'b0, 4'h0);
        wait_cycles(2 * FRAME);

        // random inputs, changed at arbitrary points inside frames
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) drive_random();
        end

        for (int i = 0; i < 3; i++) begin
            wait_cycles($urandom_range(5, 90));
            async_reset_pulse();
            wait_cycles(2 * FRAME);
        end

        // active-high instance
        @(negedge clk);
        drive(16'h8888, 4'h0, 1'b0, 4'hF);
        rst2_n = 1'b1;
        wait_cycles(2 * FRAME + 3);
        for (int i = 0; i < 4; i++) begin
            check("hi_cath", {24'h0, cath2}, 32'h7F);
            check("hi_onehot", $countones(an2), 32'd1);
            wait_cycles(CLK_DIV);
        end
        @(posedge clk);
        #3 rst2_n = 1'b0;
        #1;
        check("hi_arst_an", {28'h0, an2}, 32'h0);
        check("hi_arst_cath", {24'h0, cath2}, 32'h0);
        wait_cycles(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
